// File: rtl/store_buffer.sv
// store_buffer: lane-aligns committed stores into 64-bit words with byte
// strobes, queues them in a DEPTH-entry FIFO and drains them in order to the
// data SRAM over a req/ack handshake.
// Optional macro STORE_BUF_FWD_EN: enables the ld_conflict probe of pending
// store doublewords; when undefined ld_conflict is tied low.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [3:0]               st_size,
    input  logic [63:0]              st_data,
    output logic                     sram_req,
    input  logic                     sram_ack,
    output logic [AW-1:0]            sram_addr,
    output logic [63:0]              sram_wdata,
    output logic [7:0]               sram_wstrb,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_conflict
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entries keep only the doubleword address; the byte offset lives in the strobes.
    logic [AW-4:0]    addr_q [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [7:0]       strb_q [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic [2:0]       off;
    logic [7:0]       aln_strb;
    logic [63:0]      aln_data;
    logic             size_ok;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;

    assign off   = st_addr[2:0];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Lane alignment: replicate the low-aligned data across the word and
    // place the strobe at the naturally aligned slot for the access size.
    always_comb begin
        aln_strb = '0;
        aln_data = '0;
        size_ok  = 1'b1;
        case (st_size)
            4'b0001: begin
                aln_strb = 8'h01 << off;
                aln_data = {8{st_data[7:0]}};
            end
            4'b0010: begin
                aln_strb = 8'h03 << {off[2:1], 1'b0};
                aln_data = {4{st_data[15:0]}};
            end
            4'b0100: begin
                aln_strb = 8'h0F << {off[2], 2'b00};
                aln_data = {2{st_data[31:0]}};
            end
            4'b1000: begin
                aln_strb = 8'hFF;
                aln_data = st_data;
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign st_ready = rst_n & ~full;
    // A malformed size still completes the handshake but is dropped here.
    assign enq      = st_valid & st_ready & size_ok;
    assign deq      = sram_req & sram_ack;

    // Pointer, occupancy and valid-bit bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (enq) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (deq) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr] <= st_addr[AW-1:3];
            data_q[wr_ptr] <= aln_data;
            strb_q[wr_ptr] <= aln_strb;
        end
    end

    assign sram_req   = ~empty;
    assign sram_addr  = {addr_q[rd_ptr], 3'b000};
    assign sram_wdata = data_q[rd_ptr];
    assign sram_wstrb = strb_q[rd_ptr];
    assign sb_empty   = empty;
    assign sb_count   = count;

`ifdef STORE_BUF_FWD_EN
    // Flag any pending store in the same doubleword as the probed load.
    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_q[i] == ld_addr[AW-1:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd  = ^{ld_addr, valid};
    assign ld_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven alignment vectors plus hand-written FIFO
// sequences; every SRAM write is compared against a scoreboard entry pushed
// when the store was accepted.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [3:0]  st_size;
    logic [63:0] st_data;
    logic        sram_req;
    logic        sram_ack;
    logic [63:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_wstrb;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic [63:0] ld_addr;
    logic        ld_conflict;

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    store_buffer #(.DEPTH(4), .AW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .sram_req(sram_req), .sram_ack(sram_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb),
        .sb_empty(sb_empty), .sb_count(sb_count),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } wr_t;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  size;
        logic [63:0] data;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
    } vec_t;

    wr_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit onehot4(input logic [3:0] s);
        return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
    endfunction

    // Reference: lane j gets source byte (j mod n); strobes cover the
    // naturally aligned n-byte slot containing the address.
    function automatic wr_t model(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
        wr_t r;
        int unsigned n, base;
        n    = (s == 4'd1) ? 1 : (s == 4'd2) ? 2 : (s == 4'd4) ? 4 : 8;
        base = (int'(a[2:0]) / n) * n;
        r.addr = {a[63:3], 3'b000};
        r.strb = '0;
        r.wdata = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            r.wdata[8*j +: 8] = d[8*(j % n) +: 8];
            r.strb[j]         = (j >= base) && (j < base + n);
        end
        return r;
    endfunction

    // One clock: settle, score any write handshake, record any accepted
    // store, then advance to just after the next rising edge.
    task automatic tick(output bit acc);
        wr_t e;
        #1;
        acc = st_valid && st_ready;
        if (rst_n && sram_req && sram_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h required=none", sram_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", sram_addr, e.addr);
                chk("wr_data", sram_wdata, e.wdata);
                chk("wr_strb", 64'(sram_wstrb), 64'(e.strb));
            end
        end
        if (acc && onehot4(st_size)) sb.push_back(model(st_addr, st_size, st_data));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
        bit acc;
        acc = 1'b0;
        st_valid = 1'b1;
        st_addr  = a;
        st_size  = s;
        st_data  = d;
        for (int k = 0; k < 16 && !acc; k++) tick(acc);
        st_valid = 1'b0;
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bit acc;
        sram_ack = 1'b1;
        for (int k = 0; k < 20 && !sb_empty; k++) tick(acc);
        sram_ack = 1'b0;
        chk("drain_empty", 64'(sb_empty), 64'd1);
        chk("sb_leftover", 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        bit acc;
        vecs[0] = '{64'h1003, 4'b0001, 64'hAB,               64'h1000, 64'hABABABAB_ABABABAB, 8'h08};
        vecs[1] = '{64'h2006, 4'b0010, 64'h1234,             64'h2000, 64'h12341234_12341234, 8'hC0};
        vecs[2] = '{64'h2005, 4'b0100, 64'hDEADBEEF,         64'h2000, 64'hDEADBEEF_DEADBEEF, 8'hF0};
        vecs[3] = '{64'h3007, 4'b1000, 64'h01234567_89ABCDEF, 64'h3000, 64'h01234567_89ABCDEF, 8'hFF};
        vecs[4] = '{64'h4000, 4'b0001, 64'h11223344_55667788, 64'h4000, 64'h88888888_88888888, 8'h01};
        vecs[5] = '{64'h4001, 4'b0010, 64'hCAFE,             64'h4000, 64'hCAFECAFE_CAFECAFE, 8'h03};
        vecs[6] = '{64'h4003, 4'b0100, 64'h0BADF00D,         64'h4000, 64'h0BADF00D_0BADF00D, 8'h0F};
        vecs[7] = '{64'h400F, 4'b0001, 64'h77,               64'h4008, 64'h77777777_77777777, 8'h80};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
        sram_ack = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(sram_req), 64'd0);
        chk("rst_empty", 64'(sb_empty), 64'd1);
        chk("rst_count", 64'(sb_count), 64'd0);
        chk("rst_ready", 64'(st_ready), 64'd0);
        chk("rst_conflict", 64'(ld_conflict), 64'd0);
        rst_n = 1'b1;
        tick(acc);

        // Alignment vectors: enqueue, check head one cycle later, then ack.
        for (int i = 0; i < 8; i++) begin
            chk("req_before", 64'(sram_req), 64'd0);
            st_valid = 1'b1; st_addr = vecs[i].addr; st_size = vecs[i].size; st_data = vecs[i].data;
            tick(acc);
            st_valid = 1'b0;
            chk("vec_req", 64'(sram_req), 64'd1);
            chk("vec_addr", sram_addr, vecs[i].exp_addr);
            chk("vec_data", sram_wdata, vecs[i].exp_wdata);
            chk("vec_strb", 64'(sram_wstrb), 64'(vecs[i].exp_strb));
            sram_ack = 1'b1;
            tick(acc);
            sram_ack = 1'b0;
            chk("vec_empty", 64'(sb_empty), 64'd1);
        end

        // Fill with no ack, head must hold, then drain in order.
        for (int i = 0; i < 4; i++) send(64'h5000 + 64'(i * 9), 4'b0001 << (i % 4), 64'h0F0E0D0C_0B0A0900 + 64'(i));
        chk("full_count", 64'(sb_count), 64'd4);
        chk("full_ready", 64'(st_ready), 64'd0);
        repeat (2) tick(acc);
        chk("hold_addr", sram_addr, sb[0].addr);
        chk("hold_data", sram_wdata, sb[0].wdata);
        chk("hold_strb", 64'(sram_wstrb), 64'(sb[0].strb));
        drain();

        // Full with dequeue and store in the same cycle: no bypass.
        for (int i = 0; i < 4; i++) send(64'h6000 + 64'(i * 8), 4'b1000, 64'hA5A5_0000 + 64'(i));
        st_valid = 1'b1; st_addr = 64'h7002; st_size = 4'b0010; st_data = 64'hBEEF;
        sram_ack = 1'b1;
        #1;
        chk("full_ack_ready", 64'(st_ready), 64'd0);
        tick(acc);
        chk("full_ack_acc", 64'(acc), 64'd0);
        chk("after_deq_count", 64'(sb_count), 64'd3);
        chk("after_deq_ready", 64'(st_ready), 64'd1);
        sram_ack = 1'b0;
        tick(acc);
        st_valid = 1'b0;
        chk("refill_acc", 64'(acc), 64'd1);
        chk("refill_count", 64'(sb_count), 64'd4);
        sram_ack = 1'b1;
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom}, 4'b0001 << $urandom_range(3), {$urandom, $urandom});
        drain();

        // Reset mid-handshake drops everything.
        for (int i = 0; i < 3; i++) send(64'h8000 + 64'(i * 8), 4'b1000, 64'(i + 1));
        chk("pre_rst_req", 64'(sram_req), 64'd1);
        sram_ack = 1'b1;
        rst_n = 1'b0;
        tick(acc);
        chk("mid_rst_req", 64'(sram_req), 64'd0);
        chk("mid_rst_count", 64'(sb_count), 64'd0);
        chk("mid_rst_empty", 64'(sb_empty), 64'd1);
        chk("mid_rst_ready", 64'(st_ready), 64'd0);
        sb.delete();
        sram_ack = 1'b0;
        rst_n = 1'b1;
        tick(acc);
        send(64'h9000, 4'b0000, 64'h55);
        send(64'h9000, 4'b0011, 64'h66);
        chk("bad_size_empty", 64'(sb_empty), 64'd1);
        chk("bad_size_count", 64'(sb_count), 64'd0);

        // Load conflict probe.
        send(64'h3000, 4'b1000, 64'h1111_2222);
        ld_addr = 64'h3004;
        #1;
        chk("conflict_same_dw", 64'(ld_conflict), 64'(FWD));
        ld_addr = 64'h3008;
        #1;
        chk("conflict_next_dw", 64'(ld_conflict), 64'd0);
        ld_addr = 64'h3004;
        drain();
        #1;
        chk("conflict_drained", 64'(ld_conflict), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
